imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Host-side writer for the fetch stage's instruction-memory write port. Receives a byte stream
//  (length header + big-endian words), assembles 32-bit instructions and sequences newPC/WE/W_Ins
//  so each word lands in IMem at consecutive word addresses. Core is held off via Hold until Done.
// PARAMETERS
//  IMEM_SIZE   64       words of instruction memory; word count above this is rejected
//  BASE_ADDR   32'h0    byte address of first loaded word (word aligned)
//  TIMEOUT     16'hFFFF idle cycles allowed between bytes before abort
// PORTS
//  CLK       in   1   system clock, all logic on posedge
//  RST_N     in   1   asynchronous active-low reset
//  Start     in   1   1-cycle pulse: begin a load session (ignored unless IDLE/DONE/ERR)
//  Rx_Data   in   8   incoming byte
//  Rx_Valid  in   1   Rx_Data valid; byte consumed on cycle with Rx_Valid && Rx_Ready
//  Rx_Ready  out  1   loader can accept a byte this cycle
//  newPC     out  32  PC value presented to fetch stage
//  WE        out  1   IMem write enable (writes IMem[PC>>2] at next edge)
//  W_Ins     out  32  instruction word to write
//  Hold      out  1   keeps core in reset/stall while loading
//  Busy      out  1   session active
//  Done      out  1   sticky: last load completed OK; cleared by Start
//  Err       out  1   sticky: length overflow or timeout; cleared by Start
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE; newPC=BASE_ADDR; WE=0; W_Ins=0; Rx_Ready=0; Hold=0;
//   Busy=0; Done=0; Err=0; all counters 0. Reset mid-session discards it; no partial WE.
//  States: IDLE -> LEN0 -> LEN1 -> BYTE -> SETPC -> WRITE -> (BYTE | DONE); any -> ERR.
//  IDLE/DONE/ERR: Rx_Ready=0. Start -> LEN0; Done,Err cleared; Hold=1, Busy=1 from next cycle.
//  LEN0/LEN1: Rx_Ready=1; accept count[15:8] then count[7:0]. After LEN1:
//   count==0 -> DONE; count>IMEM_SIZE -> ERR; else word_idx=0, byte_idx=0 -> BYTE.
//  BYTE: Rx_Ready=1; shift: W_Ins <= {W_Ins[23:0],Rx_Data}; first byte is bits[31:24].
//   4th byte accepted -> SETPC.
//  SETPC (1 cycle): Rx_Ready=0; newPC = BASE_ADDR + (word_idx<<2) so fetch PC equals target
//   at the next edge.
//  WRITE (1 cycle): WE=1, newPC held at same address, W_Ins stable; word_idx++.
//   word_idx+1==count -> DONE, else byte_idx=0 -> BYTE. WE is 1 in no other state.
//  Each word: 4 accepted bytes + 2 cycles; minimum 6 cycles/word.
//  DONE: Done=1, Hold=0, Busy=0, newPC=BASE_ADDR (core starts from base after release).
//  ERR: Err=1, Hold stays 1 until next Start or reset; Busy=0; no further WE.
//  Timeout: 16-bit counter counts cycles in LEN0/LEN1/BYTE with no accepted byte; reset on
//   each accepted byte; reaching TIMEOUT -> ERR. Not counted in SETPC/WRITE.
//  Start while Busy: ignored. Rx_Valid while Rx_Ready=0: byte not consumed (source holds it).
//  Address arithmetic 32-bit, word_idx width clog2(IMEM_SIZE)+1; no wrap possible since
//   count<=IMEM_SIZE is enforced.
// STRUCTURE
//  Shared include (common_param.vh): IMEM_SIZE, loader state encodings (localparam, 3 bits),
//   default TIMEOUT. Single module; one natural sub-module: loader_timeout (counter with
//   clear/enable/expire), instantiated once. FSM in one always block, async reset.
// TESTING
//  1 Reset mid-BYTE (RST_N low 1 cycle) -> all outputs reset values, WE never pulses, IDLE.
//  2 Start; bytes 00 02 | 20 08 00 05 | 8C 09 00 00 -> WE pulses twice: newPC=0,W_Ins=32'h20080005;
//    newPC=4,W_Ins=32'h8C090000; Done=1, Hold=0, fetch Ins at PC 0 reads 32'h20080005.
//  3 Header 00 41 (65 > IMEM_SIZE) -> Err=1 next cycle, no WE, Hold=1.
//  4 Header 00 01, two data bytes then Rx_Valid low for TIMEOUT cycles -> Err=1, no WE.
//  5 Header 00 00 -> Done=1 immediately after LEN1, no WE; Start during Busy ignored.
//  6 Rx_Valid toggled randomly during a 64-word load -> all 64 words written in order,
//    addresses 0..252, exactly 64 WE pulses, each preceded by one SETPC cycle.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default sizes, state
// encoding and the word-address helper.
package imem_loader_pkg;

    localparam int          IMEM_SIZE_DEF = 64;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0;
    localparam logic [15:0] TIMEOUT_DEF   = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_BYTE  = 3'd3,
        ST_SETPC = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count would reach LIMIT.
module imem_loader_timeout
    import imem_loader_pkg::*;
#(
    parameter logic [15:0] LIMIT = TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [15:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= 16'd0;
        end else if (clear || !enable) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Fires on the LIMIT-th consecutive idle cycle so the FSM leaves on that edge.
    assign expire = enable && !clear && (cnt == LIMIT - 16'd1);

endmodule

// File: rtl/imem_loader.sv
// Host-side instruction-memory loader: parses a length header plus big-endian
// words from a byte stream and drives newPC/WE/W_Ins one word at a time.
// Rx handshake: a byte is consumed on a cycle with Rx_Valid && Rx_Ready; the source holds it otherwise.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          IMEM_SIZE = IMEM_SIZE_DEF,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter logic [15:0] TIMEOUT   = TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Start,
    input  logic [7:0]  Rx_Data,
    input  logic        Rx_Valid,
    output logic        Rx_Ready,
    output logic [31:0] newPC,
    output logic        WE,
    output logic [31:0] W_Ins,
    output logic        Hold,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [2:0]  dbg_state
);

    localparam int          IDX_W  = $clog2(IMEM_SIZE) + 1;
    localparam logic [15:0] SIZE16 = 16'(IMEM_SIZE);

    state_t            state, state_nxt;
    logic [7:0]        len_hi;
    logic [15:0]       count;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       ins;
    logic              accept;
    logic              expire;
    logic [15:0]       len_word;
    logic              last_word;

    assign accept    = Rx_Valid && Rx_Ready;
    assign len_word  = {len_hi, Rx_Data};
    assign last_word = ({{(16-IDX_W){1'b0}}, word_idx} + 16'd1) == count;

    imem_loader_timeout #(.LIMIT(TIMEOUT)) u_timeout (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .clear  (accept),
        .enable (Rx_Ready),
        .expire (expire)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (Start) state_nxt = ST_LEN0;
            end
            ST_LEN0: begin
                if (expire)      state_nxt = ST_ERR;
                else if (accept) state_nxt = ST_LEN1;
            end
            ST_LEN1: begin
                if (expire) begin
                    state_nxt = ST_ERR;
                end else if (accept) begin
                    if (len_word == 16'd0)      state_nxt = ST_DONE;
                    else if (len_word > SIZE16) state_nxt = ST_ERR;
                    else                        state_nxt = ST_BYTE;
                end
            end
            ST_BYTE: begin
                if (expire)                             state_nxt = ST_ERR;
                else if (accept && byte_idx == 2'd3)    state_nxt = ST_SETPC;
            end
            ST_SETPC: state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_word ? ST_DONE : ST_BYTE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            len_hi   <= 8'd0;
            count    <= 16'd0;
            word_idx <= '0;
            byte_idx <= 2'd0;
            ins      <= 32'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (Start) begin
                        count    <= 16'd0;
                        word_idx <= '0;
                        byte_idx <= 2'd0;
                    end
                end
                ST_LEN0: if (accept) len_hi <= Rx_Data;
                ST_LEN1: begin
                    if (accept) begin
                        count    <= len_word;
                        word_idx <= '0;
                        byte_idx <= 2'd0;
                    end
                end
                ST_BYTE: begin
                    if (accept) begin
                        ins      <= {ins[23:0], Rx_Data};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                ST_WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    byte_idx <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    // newPC leads WE by one cycle so the fetch PC register already holds the target when WE is high.
    assign Rx_Ready  = (state == ST_LEN0) || (state == ST_LEN1) || (state == ST_BYTE);
    assign WE        = (state == ST_WRITE);
    assign Busy      = Rx_Ready || (state == ST_SETPC) || (state == ST_WRITE);
    assign Hold      = Busy || (state == ST_ERR);
    assign Done      = (state == ST_DONE);
    assign Err       = (state == ST_ERR);
    assign W_Ins     = ins;
    assign newPC     = ((state == ST_SETPC) || (state == ST_WRITE))
                       ? word_addr(BASE_ADDR, 32'(word_idx)) : BASE_ADDR;
    assign dbg_state = state;

endmodule
